// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: autonomous job controller for the 8-tap int8 conv1d engine.
// Accepts a job descriptor, loads and runs the engine, then streams result words out.
module conv1d_sequencer #(
  parameter int MAX_LEN      = 1024,
  parameter int WAIT_TIMEOUT = 4096,
  parameter int NOP_CMD      = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_len,
  input  logic [63:0] job_kernel,
  input  logic [7:0]  job_bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  eng_cmd,
  output logic [31:0] eng_inp0,
  output logic [31:0] eng_inp1,
  input  logic [31:0] eng_ret,
  input  logic        eng_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int IDX_W = $clog2(MAX_LEN / 4) + 1;
  localparam int CNT_W = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [6:0]       NOP          = 7'(NOP_CMD);
  localparam logic [31:0]      MAX_LEN_W    = 32'(MAX_LEN);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_KERN0, S_KERN1, S_BIAS, S_SIZE, S_LOAD, S_START,
    S_GUARD, S_WAIT, S_DRAIN, S_RD_ISSUE, S_RD_CAP, S_RD_HOLD
  } state_t;

  state_t           state_r, state_s;
  logic [31:0]      len_r;
  logic [63:0]      kernel_r;
  logic [7:0]       bias_r;
  logic [IDX_W-1:0] k_r, last_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             job_ready_r, in_ready_r, out_valid_r, busy_r, done_r, err_r;
  logic [31:0]      out_data_r;
  logic [1:0]       err_code_r;
  logic             job_fire_s, job_ok_s, in_fire_s, out_fire_s, last_word_s, timeout_s;

  function automatic logic len_ok(input logic [31:0] len);
    return (len != 32'd0) && (len[2:0] == 3'd0) && (len <= MAX_LEN_W);
  endfunction

  assign job_fire_s  = job_valid && job_ready_r;
  assign job_ok_s    = len_ok(job_len);
  assign in_fire_s   = in_valid && in_ready_r;
  assign out_fire_s  = out_valid_r && out_ready;
  assign last_word_s = (k_r == last_r);
  assign timeout_s   = (state_r == S_WAIT) && !eng_valid && (wait_cnt_r == TIMEOUT_LAST);

  // Next-state decode for the job sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:     if (job_fire_s && job_ok_s) state_s = S_INIT; else state_s = S_IDLE;
      S_INIT:     state_s = S_KERN0;
      S_KERN0:    state_s = S_KERN1;
      S_KERN1:    state_s = S_BIAS;
      S_BIAS:     state_s = S_SIZE;
      S_SIZE:     state_s = S_LOAD;
      S_LOAD:     if (in_fire_s && last_word_s) state_s = S_START; else state_s = S_LOAD;
      S_START:    state_s = S_GUARD;
      // eng_valid only falls after cmd 5 is sampled, so it is not trusted here.
      S_GUARD:    state_s = S_WAIT;
      S_WAIT: begin
        if (eng_valid)      state_s = S_RD_ISSUE;
        else if (timeout_s) state_s = S_DRAIN;
        else                state_s = S_WAIT;
      end
      S_DRAIN:    if (eng_valid) state_s = S_IDLE; else state_s = S_DRAIN;
      S_RD_ISSUE: state_s = S_RD_CAP;
      S_RD_CAP:   state_s = S_RD_HOLD;
      S_RD_HOLD: begin
        if (out_fire_s) state_s = last_word_s ? S_IDLE : S_RD_ISSUE;
        else            state_s = S_RD_HOLD;
      end
      default:    state_s = S_IDLE;
    endcase
  end

  // Engine command bus; NOP in every state that does not issue a command.
  always_comb begin
    eng_cmd  = NOP;
    eng_inp0 = 32'd0;
    eng_inp1 = 32'd0;
    case (state_r)
      S_INIT:  eng_cmd = 7'd0;
      S_KERN0: begin eng_cmd = 7'd2; eng_inp0 = 32'd0; eng_inp1 = kernel_r[63:32]; end
      S_KERN1: begin eng_cmd = 7'd2; eng_inp0 = 32'd1; eng_inp1 = kernel_r[31:0]; end
      S_BIAS:  begin eng_cmd = 7'd8; eng_inp0 = {24'd0, bias_r}; end
      S_SIZE:  begin eng_cmd = 7'd4; eng_inp0 = len_r; end
      S_LOAD: begin
        if (in_valid) begin
          eng_cmd  = 7'd1;
          eng_inp0 = 32'(k_r);
          eng_inp1 = in_data;
        end else begin
          eng_cmd  = NOP;
        end
      end
      S_START:    eng_cmd = 7'd5;
      S_RD_ISSUE: begin eng_cmd = 7'd3; eng_inp0 = 32'(k_r); end
      default:    eng_cmd = NOP;
    endcase
  end

  // State, descriptor, counters and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      len_r       <= 32'd0;
      kernel_r    <= 64'd0;
      bias_r      <= 8'd0;
      k_r         <= '0;
      last_r      <= '0;
      wait_cnt_r  <= '0;
      job_ready_r <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'd0;
    end else begin
      state_r     <= state_s;
      // A mid-job reset may leave the engine running, so readiness follows eng_valid.
      job_ready_r <= (state_s == S_IDLE) && eng_valid;
      in_ready_r  <= (state_s == S_LOAD);
      out_valid_r <= (state_s == S_RD_HOLD);
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_r == S_RD_HOLD) && out_fire_s && last_word_s;
      err_r       <= (job_fire_s && !job_ok_s) || timeout_s;
      wait_cnt_r  <= (state_r == S_WAIT) ? wait_cnt_r + 1'b1 : '0;

      if (job_fire_s) begin
        err_code_r <= job_ok_s ? 2'd0 : 2'd1;
      end else if (timeout_s) begin
        err_code_r <= 2'd2;
      end else begin
        err_code_r <= err_code_r;
      end

      if (job_fire_s && job_ok_s) begin
        len_r    <= job_len;
        kernel_r <= job_kernel;
        bias_r   <= job_bias;
        last_r   <= job_len[IDX_W+1:2] - 1'b1;
        k_r      <= '0;
      end else if (in_fire_s) begin
        k_r <= last_word_s ? '0 : k_r + 1'b1;
      end else if ((state_r == S_RD_HOLD) && out_fire_s && !last_word_s) begin
        k_r <= k_r + 1'b1;
      end else begin
        k_r <= k_r;
      end

      if (state_r == S_RD_CAP) begin
        out_data_r <= eng_ret;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign job_ready = job_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Bench for conv1d_sequencer: behavioural conv1d engine plus a reference of the
// expected command stream and result words, compared on every meaningful cycle.
module tb_conv1d_sequencer;
  localparam int NOP = 9;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        job_valid = 1'b0, job_ready;
  logic [31:0] job_len = 32'd0;
  logic [63:0] job_kernel = 64'd0;
  logic [7:0]  job_bias = 8'd0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic [6:0]  eng_cmd;
  logic [31:0] eng_inp0, eng_inp1, eng_ret;
  logic        eng_valid;
  logic        busy, done, err;
  logic [1:0]  err_code;

  conv1d_sequencer #(.MAX_LEN(1024), .WAIT_TIMEOUT(TMO), .NOP_CMD(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_kernel(job_kernel), .job_bias(job_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .eng_cmd(eng_cmd), .eng_inp0(eng_inp0), .eng_inp1(eng_inp1),
    .eng_ret(eng_ret), .eng_valid(eng_valid),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Conv1d result word w: byte i = bias + sum_j w_j*in[i+j-4], zero outside [0,size).
  function automatic logic [31:0] ref_word(input logic [7:0] d [1024], input int size,
                                           input logic [63:0] kern, input logic [7:0] b, input int w);
    logic [31:0] r;
    int i, idx, acc;
    r = 32'd0;
    for (int q = 0; q < 4; q++) begin
      i = 4 * w + q;
      acc = $signed(b);
      for (int j = 0; j < 8; j++) begin
        idx = i + j - 4;
        if (idx >= 0 && idx < size) acc += $signed(kern[63-8*j -: 8]) * $signed(d[idx]);
      end
      r[31-8*q -: 8] = acc[7:0];
    end
    return r;
  endfunction

  // ---------------- behavioural engine ----------------
  logic [7:0]  eng_buf [1024];
  logic [31:0] eng_res [256];
  logic [63:0] eng_kern;
  logic [7:0]  eng_bias;
  int          eng_size, lat;
  bit          running = 0, hold = 0, force_busy = 0;

  initial begin
    eng_valid = 1'b1;
    eng_ret   = 32'd0;
    forever begin
      @(posedge clk);
      if (eng_valid && eng_cmd != 7'(NOP)) begin
        case (eng_cmd)
          7'd0: begin
            for (int i = 0; i < 1024; i++) eng_buf[i] = 8'd0;
            eng_size = 0;
          end
          7'd1: for (int q = 0; q < 4; q++) eng_buf[4*eng_inp0[7:0]+q] = eng_inp1[31-8*q -: 8];
          7'd2: if (eng_inp0[0]) eng_kern[31:0] = eng_inp1; else eng_kern[63:32] = eng_inp1;
          7'd3: eng_ret <= eng_res[eng_inp0[7:0]];
          7'd4: eng_size = int'(eng_inp0);
          7'd5: begin
            for (int w = 0; w < eng_size / 4; w++) eng_res[w] = ref_word(eng_buf, eng_size, eng_kern, eng_bias, w);
            eng_valid <= 1'b0;
            running = 1;
            lat = $urandom_range(2, 10);
          end
          7'd8: eng_bias = eng_inp0[7:0];
          default: ;
        endcase
      end else if (!eng_valid) begin
        if (running) begin
          if (lat > 0) lat--;
          else if (!hold) begin eng_valid <= 1'b1; running = 0; end
        end else if (!force_busy) eng_valid <= 1'b1;
      end
      if (force_busy) eng_valid <= 1'b0;
    end
  end

  // ---------------- reference queues ----------------
  typedef struct {
    logic [6:0]  cmd;
    logic [31:0] a0, a1;
    bit          c0, c1;
  } cmd_t;
  cmd_t        exp_cmd[$];
  logic [31:0] exp_out[$];
  logic [7:0]  ref_in [1024];

  function automatic cmd_t mk(input int c, input logic [31:0] a0, input logic [31:0] a1, input bit c0, input bit c1);
    cmd_t e;
    e.cmd = 7'(c); e.a0 = a0; e.a1 = a1; e.c0 = c0; e.c1 = c1;
    return e;
  endfunction

  function automatic logic [31:0] in_word(input int w);
    return {ref_in[4*w], ref_in[4*w+1], ref_in[4*w+2], ref_in[4*w+3]};
  endfunction

  // Compare process: engine command stream, result words, stall stability, status.
  initial begin
    cmd_t        e;
    logic [31:0] exp_w, prev_data;
    bit          prev_stall;
    prev_stall = 0;
    prev_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (eng_cmd !== 7'(NOP)) begin
          if (!eng_valid) check("cmd_while_engine_busy", eng_cmd, 64'(NOP));
          else if (exp_cmd.size() == 0) check("unexpected_cmd", eng_cmd, 64'(NOP));
          else begin
            e = exp_cmd.pop_front();
            check("eng_cmd", eng_cmd, e.cmd);
            if (e.c0) check("eng_inp0", eng_inp0, e.a0);
            if (e.c1) check("eng_inp1", eng_inp1, e.a1);
          end
        end
        if (prev_stall) begin
          check("out_valid_held", out_valid, 1);
          check("out_data_stable", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) check("unexpected_out_word", out_data, 0);
          else begin
            exp_w = exp_out.pop_front();
            check("out_data", out_data, exp_w);
          end
        end
        if (busy) check("job_ready_while_busy", job_ready, 0);
        if (done) done_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic offer_job(input logic [31:0] len, input logic [63:0] kern, input logic [7:0] b);
    int n = 0;
    while (!job_ready && n < 300) begin tick(); n++; end
    check("job_ready_wait", job_ready, 1);
    job_len = len; job_kernel = kern; job_bias = b; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic push_job(input int len, input logic [63:0] kern, input logic [7:0] b, input bit reads);
    exp_cmd.push_back(mk(0, 0, 0, 0, 0));
    exp_cmd.push_back(mk(2, 0, kern[63:32], 1, 1));
    exp_cmd.push_back(mk(2, 1, kern[31:0], 1, 1));
    exp_cmd.push_back(mk(8, {24'd0, b}, 0, 1, 0));
    exp_cmd.push_back(mk(4, len, 0, 1, 0));
    for (int w = 0; w < len / 4; w++) exp_cmd.push_back(mk(1, w, in_word(w), 1, 1));
    exp_cmd.push_back(mk(5, 0, 0, 0, 0));
    if (reads) begin
      for (int w = 0; w < len / 4; w++) begin
        exp_cmd.push_back(mk(3, w, 0, 1, 0));
        exp_out.push_back(ref_word(ref_in, len, kern, b, w));
      end
    end
  endtask

  task automatic fill_in(input int len, input bit ones);
    for (int i = 0; i < 1024; i++) ref_in[i] = (i < len) ? (ones ? 8'h01 : 8'($urandom)) : 8'h00;
  endtask

  task automatic feed(input int n, input int mode);
    int  k = 0, g = 0;
    bit  hs;
    while (k < n && g < 4000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (g % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_word(k);
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      if (hs) k++;
      g++;
    end
    in_valid = 1'b0;
    check("load_complete", k, n);
  endtask

  task automatic drain_out(input int n, input int stall);
    int g, s;
    for (int w = 0; w < n; w++) begin
      g = 0;
      while (!out_valid && g < 500) begin tick(); g++; end
      if (!out_valid) begin check("out_valid_timeout", 0, 1); return; end
      s = (stall == 0) ? 0 : (stall == 1) ? 10 : $urandom_range(0, 3);
      repeat (s) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("done_pulse", done, 1);
    check("busy_cleared", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  task automatic run_job(input int len, input logic [63:0] kern, input logic [7:0] b,
                         input int in_mode, input int stall, input bit ones);
    int d0 = done_cnt;
    fill_in(len, ones);
    push_job(len, kern, b, 1);
    offer_job(len, kern, b);
    check("busy_after_accept", busy, 1);
    check("err_code_cleared", err_code, 0);
    feed(len / 4, in_mode);
    drain_out(len / 4, stall);
    check("done_count", done_cnt - d0, 1);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("out_queue_empty", exp_out.size(), 0);
  endtask

  task automatic bad_job(input logic [31:0] len);
    offer_job(len, {$urandom, $urandom}, 8'($urandom));
    check("bad_len_err", err, 1);
    check("bad_len_code", err_code, 1);
    check("bad_len_busy", busy, 0);
    tick();
    check("bad_len_err_one_cycle", err, 0);
    check("bad_len_ready_back", job_ready, 1);
    check("bad_len_code_held", err_code, 1);
    repeat (3) tick();
  endtask

  task automatic check_reset_vals();
    check("rst_eng_cmd", eng_cmd, 64'(NOP));
    check("rst_eng_inp0", eng_inp0, 0);
    check("rst_eng_inp1", eng_inp1, 0);
    check("rst_job_ready", job_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    logic [63:0] ones_k;
    ones_k = 64'h0101010101010101;
    #3;
    check_reset_vals();
    repeat (2) tick();
    reset_n = 1'b1;

    // Hand-computed pins on the reference model.
    fill_in(8, 1);
    check("pin_bias0_w0", ref_word(ref_in, 8, ones_k, 8'h00, 0), 32'h04050607);
    check("pin_bias0_w1", ref_word(ref_in, 8, ones_k, 8'h00, 1), 32'h08070605);
    check("pin_bias3_w0", ref_word(ref_in, 8, ones_k, 8'h03, 0), 32'h0708090A);
    check("pin_bias3_w1", ref_word(ref_in, 8, ones_k, 8'h03, 1), 32'h0B0A0908);

    run_job(8, ones_k, 8'h00, 0, 0, 1);
    run_job(8, ones_k, 8'h03, 0, 1, 1);

    bad_job(32'd12);
    bad_job(32'd0);
    bad_job(32'd1032);

    run_job(16, {$urandom, $urandom}, 8'($urandom), 1, 0, 0);
    for (int r = 0; r < 4; r++)
      run_job(8 * $urandom_range(1, 8), {$urandom, $urandom}, 8'($urandom), 2, 2, 0);
    run_job(1024, {$urandom, $urandom}, 8'($urandom), 0, 0, 0);

    // Engine never completes: timeout then drain.
    hold = 1;
    fill_in(8, 0);
    push_job(8, ones_k, 8'h11, 0);
    offer_job(8, ones_k, 8'h11);
    feed(2, 0);
    tick();
    g = 0;
    while (!err && g < 100) begin tick(); g++; end
    check("timeout_latency_in_range", (g >= 16 && g <= 17), 1);
    check("timeout_code", err_code, 2);
    check("timeout_busy", busy, 1);
    tick();
    check("timeout_err_one_cycle", err, 0);
    repeat (20) tick();
    check("drain_busy_held", busy, 1);
    check("drain_no_job_ready", job_ready, 0);
    hold = 0;
    g = 0;
    while (busy && g < 30) begin tick(); g++; end
    check("drain_released", busy, 0);
    check("drain_code_held", err_code, 2);
    check("timeout_cmds_done", exp_cmd.size(), 0);

    // Reset during LOAD while the engine is busy.
    fill_in(16, 0);
    push_job(16, ones_k, 8'h05, 1);
    offer_job(16, ones_k, 8'h05);
    in_valid = 1'b1;
    in_data  = in_word(0);
    g = 0;
    while (!in_ready && g < 20) begin tick(); g++; end
    tick();
    #1;
    force_busy = 1;
    reset_n    = 1'b0;
    #1;
    check_reset_vals();
    exp_cmd.delete();
    exp_out.delete();
    in_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_job_ready_low", job_ready, 0);
    end
    force_busy = 0;
    run_job(24, {$urandom, $urandom}, 8'($urandom), 2, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
